ram_sdp_reader: RTL and testbench

- Read-side engine for the 1024x32 simple-dual-port RAM.
- Drives the RAM's read port (enb/addrb) and captures its registered 1-cycle-latency output (dob).
- Streams a burst of len words, starting at base_addr, onto a valid/ready output with full backpressure.
- Sits between the RAM (written by a producer on port A) and downstream compute/stream logic.

---
 rtl/ram_sdp_reader.sv | 144 ++++++++++++++
 tb/tb_ram_sdp_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_reader.sv
// Burst read engine for a 1-cycle-latency simple-dual-port RAM, streaming onto valid/ready.
// Optional backpressure counter is built when RAM_SDP_READER_STALL_CNT_EN is defined.
module ram_sdp_reader #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [15:0]   stall_cnt
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_FIN  = 2'd2;
  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   ONE_L = {{AW{1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW:0]   issue_left_q, issue_left_d;
  logic [AW:0]   beat_left_q, beat_left_d;
  logic          inflight_q;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] buf_mem_q [2];

  logic          buf_nonempty, valid_w, pop, pop_buf, push, enb_w;
  logic [DW-1:0] head;

  // The RAM output register acts as the entry in front of the skid buffer, so the
  // first word is offered the same cycle it appears on dob.
  assign buf_nonempty = (buf_cnt_q != 2'd0);
  assign valid_w      = buf_nonempty || inflight_q;
  assign head         = buf_nonempty ? buf_mem_q[rd_ptr_q] : dob;
  assign pop          = valid_w && m_ready;
  assign pop_buf      = pop && buf_nonempty;
  assign push         = inflight_q && !(pop && !buf_nonempty);
  assign enb_w        = (state_q == S_RUN) && (issue_left_q != '0) &&
                        (({1'b0, inflight_q} + buf_cnt_q) < 2'd2);

  assign enb     = enb_w;
  assign addrb   = rd_addr_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_FIN);
  assign m_valid = valid_w;
  assign m_data  = valid_w ? head : '0;
  assign m_last  = valid_w && (beat_left_q == ONE_L);

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    buf_cnt_d    = buf_cnt_q + {1'b0, push} - {1'b0, pop_buf};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = S_FIN;
          end else begin
            rd_addr_d    = base_addr;
            issue_left_d = len;
            beat_left_d  = len;
            state_d      = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (enb_w) begin
          rd_addr_d    = rd_addr_q + ONE_A;
          issue_left_d = issue_left_q - ONE_L;
        end
        if (pop) begin
          beat_left_d = beat_left_q - ONE_L;
          if (beat_left_q == ONE_L) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      inflight_q   <= 1'b0;
      buf_cnt_q    <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      inflight_q   <= enb_w;
      buf_cnt_q    <= buf_cnt_d;
      if (push)    wr_ptr_q <= ~wr_ptr_q;
      if (pop_buf) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Buffer storage is pure data; occupancy is tracked by buf_cnt_q.
  always_ff @(posedge clk) begin
    if (push) buf_mem_q[wr_ptr_q] <= dob;
  end

`ifdef RAM_SDP_READER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = 16'd0;
    end else if (valid_w && !m_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 16'd0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ram_sdp_reader.sv
// Scoreboard bench for ram_sdp_reader with a behavioural 1-cycle-latency RAM model.
module tb_ram_sdp_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] len = '0;
  logic        busy, done, enb, m_valid, m_last;
  logic [9:0]  addrb;
  logic [31:0] dob = '0;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [15:0] stall_cnt;

  logic [31:0] mem [1024];
  logic [32:0] sb_q [$];
  int errors = 0, checks = 0;
  int issued = 0, popped = 0, beats = 0, stalls = 0, max_out = 0, done_cnt = 0;
  int rdy_mode = 0, rdy_idx = 0;
  bit held = 0;
  logic [31:0] hold_d;
  logic        hold_l;

  ram_sdp_reader #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .enb(enb), .addrb(addrb), .dob(dob),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (enb) dob <= mem[addrb];

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) m_ready = 1'b1;
    else begin
      m_ready = ((rdy_idx % 3) == 0);
      rdy_idx++;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks hold-while-stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      held = 0;
    end else begin
      if ((issued - popped) > max_out) max_out = issued - popped;
      if (held) begin
        checks++;
        if (!m_valid || m_data !== hold_d || m_last !== hold_l) begin
          errors++;
          $display("FAIL stable: valid=%0b data=%0d last=%0b, required valid=1 data=%0d last=%0b",
                   m_valid, m_data, m_last, hold_d, hold_l);
        end
      end
      if (m_valid && !m_ready) begin
        held = 1; hold_d = m_data; hold_l = m_last; stalls++;
      end else held = 0;
      if (m_valid && m_ready) begin
        logic [32:0] exp;
        checks++;
        beats++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: data=%0d, required no beat", m_data);
        end else begin
          exp = sb_q.pop_front();
          if ({m_last, m_data} !== exp) begin
            errors++;
            $display("FAIL beat%0d: data=%0d last=%0b, required data=%0d last=%0b",
                     beats - 1, m_data, m_last, exp[31:0], exp[32]);
          end
        end
      end
      if (done) done_cnt++;
      issued += int'(enb);
      popped += int'(m_valid && m_ready);
    end
  end

  task automatic do_start(input logic [9:0] b, input logic [10:0] l, input bit fresh);
    @(posedge clk); #1;
    if (fresh) begin
      issued = 0; popped = 0; beats = 0; stalls = 0; max_out = 0;
      for (int i = 0; i < int'(l); i++)
        sb_q.push_back({(i + 1 == int'(l)), mem[(int'(b) + i) % 1024]});
    end
    base_addr = b; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int done_c, output int fe,
                           output int fv, output bit any_busy);
    done_c = -1; fe = -1; fv = -1; any_busy = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk); #1;
      if (enb && fe < 0) fe = c;
      if (m_valid && fv < 0) fv = c;
      if (busy) any_busy = 1;
      if (done) begin
        done_c = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, enb, addrb, m_valid, m_data, m_last, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b enb=%0b addrb=%0d valid=%0b data=%0d last=%0b stall=%0d, required all 0",
               busy, done, enb, addrb, m_valid, m_data, m_last, stall_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_burst24;
    int dc, fe, fv; bit ab;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
    mem[0] = 95; mem[23] = 99;
    rdy_mode = 0;
    do_start(10'd0, 11'd24, 1);
    wait_done(60, dc, fe, fv, ab);
    checks++;
    if (fe != 1 || fv != 2 || dc != 26) begin
      errors++;
      $display("FAIL burst24_latency: enb=%0d valid=%0d done=%0d, required 1 2 26", fe, fv, dc);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || beats != 24 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL burst24_end: busy=%0b done=%0b beats=%0d left=%0d, required 0 0 24 0",
               busy, done, beats, sb_q.size());
    end
  endtask

  task automatic test_len0;
    int dc, fe, fv; bit ab;
    do_start(10'd5, 11'd0, 1);
    wait_done(10, dc, fe, fv, ab);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dc != 1 || fe != -1 || fv != -1 || ab || issued != 0) begin
      errors++;
      $display("FAIL len0: done=%0d enb=%0d valid=%0d busy=%0b issued=%0d, required 1 -1 -1 0 0",
               dc, fe, fv, ab, issued);
    end
  endtask

  task automatic test_wrap;
    int dc, fe, fv; bit ab;
    int exp_a [4] = '{1022, 1023, 0, 1};
    int na = 0;
    for (int i = 0; i < 1024; i++) mem[i] = i;
    rdy_mode = 0;
    do_start(10'd1022, 11'd4, 1);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk); #1;
      if (enb) begin
        checks++;
        if (na >= 4 || int'(addrb) != exp_a[na]) begin
          errors++;
          $display("FAIL wrap_addr%0d: addrb=%0d, required %0d", na, addrb, (na < 4) ? exp_a[na] : -1);
        end
        na++;
      end
    end
    wait_done(5, dc, fe, fv, ab);
    checks++;
    if (na != 4 || beats != 4 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count: reads=%0d beats=%0d, required 4 4", na, beats);
    end
  endtask

  task automatic test_backpressure;
    int dc, fe, fv; bit ab;
    rdy_idx = 0; rdy_mode = 1;
    do_start(10'd300, 11'd8, 1);
    wait_done(200, dc, fe, fv, ab);
    @(negedge clk); #1;
    rdy_mode = 0;
    checks++;
    if (dc < 0 || beats != 8 || sb_q.size() != 0 || max_out > 2 || stalls == 0) begin
      errors++;
      $display("FAIL backpressure: done=%0d beats=%0d left=%0d max_out=%0d stalls=%0d, required beats=8 left=0 max_out<=2 stalls>0",
               dc, beats, sb_q.size(), max_out, stalls);
    end
    checks++;
`ifdef RAM_SDP_READER_STALL_CNT_EN
    if (int'(stall_cnt) != stalls) begin
`else
    if (stall_cnt !== 16'd0) begin
`endif
      errors++;
      $display("FAIL stall_cnt: got %0d, tb stall cycles %0d", stall_cnt, stalls);
    end
  endtask

  task automatic test_ignore_start;
    int dc, fe, fv; bit ab;
    int d0;
    rdy_mode = 0;
    d0 = done_cnt;
    do_start(10'd100, 11'd6, 1);
    @(posedge clk); #1;
    base_addr = 10'd500; len = 11'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, dc, fe, fv, ab);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (dc < 0 || beats != 6 || issued != 6 || sb_q.size() != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignore_start: done=%0d beats=%0d issued=%0d dones=%0d, required beats=6 issued=6 dones=1",
               dc, beats, issued, done_cnt - d0);
    end
  endtask

  task automatic test_full_ram;
    int dc, fe, fv; bit ab;
    rdy_mode = 0;
    do_start(10'd5, 11'd1024, 1);
    wait_done(1100, dc, fe, fv, ab);
    #1;
    checks++;
    if (dc != 1026 || beats != 1024 || addrb !== 10'd5) begin
      errors++;
      $display("FAIL full_ram: done=%0d beats=%0d addrb=%0d, required 1026 1024 5", dc, beats, addrb);
    end
  endtask

  task automatic test_reset_mid;
    int dc, fe, fv; bit ab;
    int d0;
    rdy_mode = 0;
    do_start(10'd40, 11'd10, 1);
    for (int c = 0; c < 30 && beats < 3; c++) @(posedge clk);
    #2;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, enb, addrb, m_valid, m_data, m_last} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%0b done=%0b enb=%0b addrb=%0d valid=%0b data=%0d last=%0b, required all 0",
               busy, done, enb, addrb, m_valid, m_data, m_last);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: dones=%0d busy=%0b, required 0 0", done_cnt - d0, busy);
    end
    do_start(10'd7, 11'd5, 1);
    wait_done(40, dc, fe, fv, ab);
    #1;
    checks++;
    if (dc != 7 || beats != 5 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_restart: done=%0d beats=%0d left=%0d, required 7 5 0", dc, beats, sb_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_burst24();
    test_len0();
    test_wrap();
    test_backpressure();
    test_ignore_start();
    test_full_ram();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
